dac_sample_scheduler: RTL and testbench

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

---
 rtl/dac_pkg.sv | 19 +
 rtl/dac_tick_gen.sv | 25 ++
 rtl/dac_sample_scheduler.sv | 154 +++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared definitions for the DAC sample scheduler.
//   dac_state_e     frame FSM states
//   DAC_CFG         command nibble sent ahead of every code
//                   (channel A, unbuffered, 1x gain, active)
//   DAC_MIDSCALE    offset-binary code for silence
//   DAC_FRAME_BITS  bits per serial frame
//   dac_code()      signed 16-bit sample -> 12-bit offset-binary code
package dac_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} dac_state_e;

  localparam logic [3:0]  DAC_CFG        = 4'b0011;
  localparam logic [11:0] DAC_MIDSCALE   = 12'h800;
  localparam int          DAC_FRAME_BITS = 16;

  // Flipping the sign bit turns two's complement into offset binary.
  function automatic logic [11:0] dac_code(input logic [15:0] s);
    return {~s[15], s[14:4]};
  endfunction
endpackage

// File: rtl/dac_tick_gen.sv
// dac_tick_gen: free-running sample-rate divider.
//   clk_25mhz  in   system clock
//   reset      in   async, active-high; counter restarts at 0
//   tick       out  one-cycle strobe every CLK_HZ/SAMPLE_HZ cycles
module dac_tick_gen #(
  parameter int CLK_HZ    = 25_000_000,
  parameter int SAMPLE_HZ = 48_000
) (
  input  logic clk_25mhz,
  input  logic reset,
  output logic tick
);
  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_25mhz or posedge reset)
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);

  assign tick = (cnt == LAST);
endmodule

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: arbitrates two sample sources at the DAC update
// rate and serialises one 16-bit command word per tick.
//   clk_25mhz               in   system clock
//   reset                   in   async, active-high
//   src0/1_valid, _data     in   pending signed sample per requester
//   src0/1_ready            out  accept strobe, tick cycle only
//   mute                    in   send midscale instead of the sample
//   dac_cs_n/sclk/sdo       out  SPI-style DAC link, MSB first, sclk idle low
//   frame_done              out  pulse in the last cycle of a frame
//   underrun                out  pulse when a tick finds no requester
// Frame timing (H = SCLK_HALF): tick cycle, SETUP for one full SCLK period
// (2H), 16 bits of H high + H low, HOLD for H with cs_n high. That totals
// 2H*17 + H + 1 cycles, frame_done landing 35H cycles after the tick.
module dac_sample_scheduler
  import dac_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int SAMPLE_HZ = 48_000,
  parameter int SCLK_HALF = 2
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        src0_valid,
  input  logic [15:0] src0_data,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [15:0] src1_data,
  output logic        src1_ready,
  input  logic        mute,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdo,
  output logic        frame_done,
  output logic        underrun
);
  localparam int TICK_DIV  = CLK_HZ / SAMPLE_HZ;
  localparam int FRAME_LEN = 2 * SCLK_HALF * 17 + SCLK_HALF + 1;
  localparam int PW        = $clog2(2 * SCLK_HALF);
  localparam int BW        = $clog2(DAC_FRAME_BITS);
  localparam logic [PW-1:0] PH_HI_END = PW'(SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_END    = PW'(2 * SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DAC_FRAME_BITS - 1);

  // A frame must finish before the next tick, so IDLE never misses one.
  if (FRAME_LEN >= TICK_DIV) begin : g_frame_too_long
    $error("dac_sample_scheduler: frame length must be shorter than the tick period");
  end

  logic tick;

  dac_tick_gen #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ)) u_tick (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .tick      (tick)
  );

  dac_state_e    state, state_nxt;
  logic [PW-1:0] ph, ph_nxt;          // phase within the current SCLK period
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [15:0]   shreg, sh_nxt;       // sdo is always shreg[15]
  logic          last_grant, lg_nxt;  // 1 = src1 was granted last
  logic [11:0]   last_code, lc_nxt;
  logic [11:0]   code;
  logic          gnt1, take;

  always_ff @(posedge clk_25mhz or posedge reset)
    if (reset) begin
      state      <= IDLE;
      ph         <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      last_grant <= 1'b1;
      last_code  <= DAC_MIDSCALE;
    end else begin
      state      <= state_nxt;
      ph         <= ph_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= sh_nxt;
      last_grant <= lg_nxt;
      last_code  <= lc_nxt;
    end

  always_comb begin
    state_nxt  = state;
    ph_nxt     = ph;
    bit_nxt    = bit_cnt;
    sh_nxt     = shreg;
    lg_nxt     = last_grant;
    lc_nxt     = last_code;
    code       = last_code;
    take       = 1'b0;
    gnt1       = 1'b0;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    underrun   = 1'b0;
    frame_done = 1'b0;
    dac_cs_n   = 1'b1;
    dac_sclk   = 1'b0;
    dac_sdo    = 1'b0;
    case (state)
      IDLE: if (tick) begin
        take = src0_valid | src1_valid;
        // src1 wins when alone, or on a tie if src0 went last.
        gnt1 = src1_valid & (~src0_valid | ~last_grant);
        if (take) begin
          src0_ready = ~gnt1;
          src1_ready = gnt1;
          lg_nxt     = gnt1;
          code       = mute ? DAC_MIDSCALE : dac_code(gnt1 ? src1_data : src0_data);
        end else begin
          underrun = 1'b1;
        end
        lc_nxt    = code;
        sh_nxt    = {DAC_CFG, code};
        ph_nxt    = '0;
        bit_nxt   = '0;
        state_nxt = SETUP;
      end
      SETUP: begin
        dac_cs_n = 1'b0;
        dac_sdo  = shreg[15];
        if (ph == PH_END) begin
          ph_nxt    = '0;
          state_nxt = SHIFT;
        end else begin
          ph_nxt = ph + PW'(1);
        end
      end
      SHIFT: begin
        dac_cs_n = 1'b0;
        dac_sdo  = shreg[15];
        dac_sclk = (ph <= PH_HI_END);
        // Shift as sclk falls so sdo is stable across each high phase.
        if (ph == PH_HI_END) sh_nxt = {shreg[14:0], 1'b0};
        if (ph == PH_END) begin
          ph_nxt = '0;
          if (bit_cnt == BIT_LAST) state_nxt = HOLD;
          else                     bit_nxt   = bit_cnt + BW'(1);
        end else begin
          ph_nxt = ph + PW'(1);
        end
      end
      HOLD: begin
        if (ph == PH_HI_END) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          ph_nxt = ph + PW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
module tb_dac_sample_scheduler;
  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        src0_valid, src1_valid, mute;
  logic [15:0] src0_data, src1_data;
  logic        src0_ready, src1_ready;
  logic        dac_cs_n, dac_sclk, dac_sdo, frame_done, underrun;

  dac_sample_scheduler dut (
    .clk_25mhz (clk_25mhz), .reset (reset),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .mute      (mute),
    .dac_cs_n  (dac_cs_n), .dac_sclk(dac_sclk), .dac_sdo(dac_sdo),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus table: inputs per tick and the bench's expected outcome.
  typedef struct packed {
    logic v0, v1, m, pulse;
    logic [15:0] d0, d1;
    logic r0, r1, u;
    logic [15:0] w;
  } ent_t;
  localparam int N = 12;
  ent_t tbl[N];

  task automatic set(input int i, input logic v0, v1, m, p, input logic [15:0] d0, d1,
                     input logic r0, r1, u, input logic [15:0] w);
    tbl[i] = {v0, v1, m, p, d0, d1, r0, r1, u, w};
  endtask

  // Protocol monitor and scoreboard consumer.
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, hi_sdo = 1'b0, have_tick = 1'b0;
  int          rises = 0, last_tick_cyc = 0;
  logic [15:0] sh = '0;

  always @(negedge clk_25mhz) begin
    if (reset) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; rises = 0; have_tick = 1'b0;
    end else begin
      if (src0_ready | src1_ready | underrun) begin
        if (have_tick) chk("tick_spacing", cyc - last_tick_cyc, 520);
        last_tick_cyc = cyc;
        have_tick = 1'b1;
      end
      if (frame_done) begin
        chk("frame_done_after_tick", have_tick, 1);
        chk("frame_done_latency", cyc - last_tick_cyc, 70);
      end
      if (dac_cs_n) chk("sclk_idle_low", dac_sclk, 0);
      if (prev_cs && !dac_cs_n) begin rises = 0; sh = '0; end
      if (!dac_cs_n && dac_sclk && !prev_sclk) begin
        sh = {sh[14:0], dac_sdo};
        rises++;
        hi_sdo = dac_sdo;
      end else if (dac_sclk && prev_sclk) begin
        chk("sdo_stable_high", dac_sdo, hi_sdo);
      end
      if (!prev_cs && dac_cs_n) begin
        chk("sclk_rises", rises, 16);
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("frame_word", sh, exp_q.pop_front());
      end
      prev_cs = dac_cs_n;
      prev_sclk = dac_sclk;
    end
  end

  task automatic wait_tick(output int n);
    logic got;
    got = 1'b0; n = 0;
    while (!got && n < 600) begin
      @(negedge clk_25mhz);
      n++;
      if (src0_ready | src1_ready | underrun) got = 1'b1;
    end
    chk("tick_seen", got, 1);
  endtask

  initial begin
    int n;
    set(0,  1,1,0,0, 16'h0000,16'h8000, 1,0,0, 16'h3800);
    set(1,  1,1,0,0, 16'h0000,16'h8000, 0,1,0, 16'h3000);
    set(2,  1,1,0,0, 16'h0000,16'h8000, 1,0,0, 16'h3800);
    set(3,  1,1,0,0, 16'h0000,16'h8000, 0,1,0, 16'h3000);
    set(4,  1,0,0,0, 16'h7FF0,16'h0000, 1,0,0, 16'h3FFF);
    set(5,  1,0,0,0, 16'h1230,16'h0000, 1,0,0, 16'h3923);
    set(6,  0,0,0,0, 16'h0000,16'h0000, 0,0,1, 16'h3923);
    set(7,  0,1,1,0, 16'h0000,16'h8000, 0,1,0, 16'h3800);
    set(8,  0,0,0,1, 16'h7FF0,16'h0000, 0,0,1, 16'h3800);
    set(9,  0,1,0,0, 16'h0000,16'h1234, 0,1,0, 16'h3923);
    set(10, 1,1,0,0, 16'hFFF0,16'h0000, 1,0,0, 16'h37FF);
    set(11, 1,1,1,0, 16'h1111,16'h2222, 0,1,0, 16'h3800);

    reset = 1'b1; mute = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0; src0_data = '0; src1_data = '0;
    repeat (3) @(posedge clk_25mhz);
    #1;
    chk("rst_cs_n", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 0);
    chk("rst_sdo", dac_sdo, 0);
    chk("rst_ready", {src0_ready, src1_ready}, 0);
    chk("rst_pulses", {frame_done, underrun}, 0);
    @(posedge clk_25mhz); #1 reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      src0_data = tbl[i].d0; src1_data = tbl[i].d1; mute = tbl[i].m;
      if (tbl[i].pulse) begin
        // valid that drops before the tick must not be granted
        repeat (100) @(negedge clk_25mhz);
        src0_valid = 1'b1;
        repeat (10) @(negedge clk_25mhz);
        src0_valid = 1'b0;
      end else begin
        src0_valid = tbl[i].v0; src1_valid = tbl[i].v1;
      end
      wait_tick(n);
      if (i == 0) chk("first_tick_after_reset", n, 520);
      chk($sformatf("src0_ready_%0d", i), src0_ready, tbl[i].r0);
      chk($sformatf("src1_ready_%0d", i), src1_ready, tbl[i].r1);
      chk($sformatf("underrun_%0d", i), underrun, tbl[i].u);
      exp_q.push_back(tbl[i].w);
      @(negedge clk_25mhz);
      src0_valid = 1'b0; src1_valid = 1'b0; mute = 1'b0;
      chk("ready_one_cycle", {src0_ready, src1_ready}, 0);
    end

    // Abort the last frame around bit 7.
    repeat (32) @(posedge clk_25mhz);
    #1;
    chk("mid_frame_cs_low", dac_cs_n, 0);
    reset = 1'b1;
    #1;
    chk("abort_cs_n", dac_cs_n, 1);
    chk("abort_sclk", dac_sclk, 0);
    chk("abort_sdo", dac_sdo, 0);
    exp_q.delete();
    repeat (5) @(posedge clk_25mhz);
    #1 reset = 1'b0;
    exp_q.push_back(16'h3800);  // last_code back at midscale
    wait_tick(n);
    chk("post_reset_tick", n, 520);
    chk("post_reset_underrun", underrun, 1);
    repeat (80) @(negedge clk_25mhz);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
